// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store unit between a pipeline request/response
// handshake and a word-wide data memory with combinational read data.
// Performs alignment and range checks, sub-word load extraction with optional
// sign extension, and read-modify-write for byte/halfword stores.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (accepted in IDLE only)
//   req_write, req_size, req_signed request attributes
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_fault          load result / access rejected
//   mem_address, mem_write          word-aligned address, write strobe
//   mem_write_data, mem_data        full-word write data, read data
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory word sampled (load result or old word for merge)
// WRITE | one-cycle memory write strobe
// RESP  | response held until resp_ready
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_LIMIT = 40000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_data
);

    localparam logic [31:0] C_LIMIT = 32'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic [31:0] r_old;

    logic        w_accept;
    logic        w_req_fault;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Checks are made on the raw request so the fault path skips memory entirely.
    assign w_req_fault = (req_size == 2'b11)
                       | ((req_size == 2'b01) & req_addr[0])
                       | ((req_size == 2'b10) & (|req_addr[1:0]))
                       | (req_addr >= C_LIMIT);

    // Lane extraction of the current memory word
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_data[7:0];
            2'd1:    w_byte = mem_data[15:8];
            2'd2:    w_byte = mem_data[23:16];
            default: w_byte = mem_data[31:24];
        endcase
        w_half = r_addr[1] ? mem_data[31:16] : mem_data[15:0];
        case (r_size)
            2'b00:   w_load = {{24{w_byte[7] & r_signed}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & r_signed}}, w_half};
            default: w_load = mem_data;
        endcase
    end

    // Merge store data into the old word; word stores bypass the merge
    always_comb begin
        w_merged = r_old;
        case (r_size)
            2'b00: begin
                case (r_addr[1:0])
                    2'd0:    w_merged[7:0]   = r_wdata[7:0];
                    2'd1:    w_merged[15:8]  = r_wdata[7:0];
                    2'd2:    w_merged[23:16] = r_wdata[7:0];
                    default: w_merged[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
                else           w_merged[15:0]  = r_wdata[15:0];
            end
            default: w_merged = r_wdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_fault)           w_next = S_RESP;
                    else if (!req_write)       w_next = S_READ;
                    else if (req_size == 2'b10) w_next = S_WRITE;
                    else                       w_next = S_READ;
                end
            end
            S_READ:  w_next = r_write ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready      = (r_state == S_IDLE);
        resp_valid     = (r_state == S_RESP);
        resp_rdata     = (r_state == S_RESP) ? r_rdata : 32'h0;
        resp_fault     = (r_state == S_RESP) & r_fault;
        mem_write      = (r_state == S_WRITE);
        mem_write_data = (r_state == S_WRITE) ? w_merged : 32'h0;
        mem_address    = {r_addr[31:2], 2'b00};
    end

    // Request latch and data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= 32'h0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_wdata  <= 32'h0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'h0;
            r_old    <= 32'h0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_write  <= req_write;
                r_wdata  <= req_wdata;
                r_fault  <= w_req_fault;
                r_rdata  <= 32'h0;
                r_old    <= 32'h0;
            end else if (r_state == S_READ) begin
                if (r_write) r_old   <= mem_data;
                else         r_rdata <= w_load;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a 16-word memory model (address
// bits [5:2] select the word), hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data;

    logic [31:0] mem [0:15];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wcnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    load_store_unit #(.ADDR_LIMIT(40000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mem_address[5:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[5:2]] <= mem_write_data;
    end

    always @(negedge clk) begin
        if (mem_write) begin
            wcnt       = wcnt + 1;
            last_waddr = mem_address;
            last_wdata = mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One full transaction; lat counts edges from accept until resp_valid seen.
    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic flt,
                       output int nw);
        int w0;
        @(negedge clk);
        w0 = wcnt;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd  = resp_rdata;
        flt = resp_fault;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        nw = wcnt - w0;
    endtask

    int          lat;
    int          nw;
    logic [31:0] rd;
    logic        flt;
    logic [31:0] hold_rd;
    int          w0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4]  = 32'h8899AABB;
        mem[5]  = 32'h12345678;
        mem[15] = 32'hCAFEF00D;

        #12;
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_write",  {31'h0, mem_write},  32'h0);
        chk("rst_mem_addr",   mem_address,         32'h0);
        chk("rst_mem_wdata",  mem_write_data,      32'h0);
        chk("rst_rdata",      resp_rdata,          32'h0);
        chk("rst_fault",      {31'h0, resp_fault}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads on 0x8899AABB at 0x10
        txn(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, flt, nw);
        chk("lb_s_0x12_data", rd, 32'hFFFFFF99);
        chk("lb_s_0x12_flt",  {31'h0, flt}, 32'h0);
        chk("lb_s_0x12_lat",  32'(lat), 32'd2);
        txn(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rd, flt, nw);
        chk("lb_u_0x12_data", rd, 32'h00000099);
        txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, flt, nw);
        chk("lb_s_0x11_data", rd, 32'hFFFFFFAA);
        txn(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, lat, rd, flt, nw);
        chk("lb_s_0x17_pos",  rd, 32'h00000012);
        txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, flt, nw);
        chk("lh_s_0x10_data", rd, 32'hFFFFAABB);
        txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, flt, nw);
        chk("lh_u_0x12_data", rd, 32'h00008899);
        txn(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, rd, flt, nw);
        chk("lw_0x10_data",   rd, 32'h8899AABB);
        chk("lw_0x10_lat",    32'(lat), 32'd2);
        chk("lw_0x10_nowr",   32'(nw), 32'd0);

        // Sub-word stores (read-modify-write)
        txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, rd, flt, nw);
        chk("sh_0x12_nwr",    32'(nw), 32'd1);
        chk("sh_0x12_addr",   last_waddr, 32'h10);
        chk("sh_0x12_wdata",  last_wdata, 32'h1234AABB);
        chk("sh_0x12_lat",    32'(lat), 32'd3);
        chk("sh_0x12_rdata",  rd, 32'h0);
        chk("sh_0x12_mem",    mem[4], 32'h1234AABB);
        txn(1'b1, 2'b00, 1'b1, 32'h15, 32'hFFFFFF55, lat, rd, flt, nw);
        chk("sb_0x15_wdata",  last_wdata, 32'h12345578);
        chk("sb_0x15_lat",    32'(lat), 32'd3);
        txn(1'b1, 2'b10, 1'b1, 32'h18, 32'hDEADBEEF, lat, rd, flt, nw);
        chk("sw_0x18_lat",    32'(lat), 32'd2);
        chk("sw_0x18_wdata",  last_wdata, 32'hDEADBEEF);
        chk("sw_0x18_addr",   last_waddr, 32'h18);
        chk("sw_0x18_nwr",    32'(nw), 32'd1);

        // Faults
        txn(1'b1, 2'b10, 1'b0, 32'h13, 32'h11111111, lat, rd, flt, nw);
        chk("sw_0x13_flt",    {31'h0, flt}, 32'h1);
        chk("sw_0x13_lat",    32'(lat), 32'd1);
        chk("sw_0x13_nwr",    32'(nw), 32'd0);
        txn(1'b0, 2'b10, 1'b0, 32'd40000, 32'h0, lat, rd, flt, nw);
        chk("lw_limit_flt",   {31'h0, flt}, 32'h1);
        chk("lw_limit_rdata", rd, 32'h0);
        txn(1'b0, 2'b10, 1'b0, 32'd39996, 32'h0, lat, rd, flt, nw);
        chk("lw_below_flt",   {31'h0, flt}, 32'h0);
        chk("lw_below_data",  rd, 32'hCAFEF00D);
        txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rd, flt, nw);
        chk("lh_odd_flt",     {31'h0, flt}, 32'h1);
        txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, flt, nw);
        chk("rsvd_size_flt",  {31'h0, flt}, 32'h1);
        chk("rsvd_size_rd",   rd, 32'h0);

        // Backpressure in RESP with a competing request held on req_valid
        @(negedge clk);
        w0 = wcnt;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("bp_valid_rise", {31'h0, resp_valid}, 32'h1);
        hold_rd = resp_rdata;
        chk("bp_rdata",      hold_rd, 32'h1234AABB);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata_hold", resp_rdata, 32'h1234AABB);
            chk("bp_ready_low",  {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_idle",       {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("bp_no_accept",  32'(wcnt - w0), 32'd0);
        chk("bp_mem_keep",   mem[5], 32'h12345578);

        // Reset during WRITE of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h000000AA;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rw_in_write",   {31'h0, mem_write}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_mem_write",  {31'h0, mem_write}, 32'h0);
        chk("rw_req_ready",  {31'h0, req_ready}, 32'h1);
        chk("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_mem_keep",   mem[5], 32'h12345578);
        chk("rw_no_resp",    {31'h0, resp_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
